// File: rtl/complex_magnitude_bfp.sv
// Streaming |I + jQ| estimator (alpha-max/beta-min) with a 3-stage stall-able
// pipeline and per-block peak / leading-zero exponent for a BFP normaliser.
module complex_magnitude_bfp #(
  parameter int WIDTH     = 16,
  parameter bit IS_SIGNED = 1'b1,
  parameter int BLOCK_LEN = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_I,
  input  logic [WIDTH-1:0]           s_Q,
  input  logic [1:0]                 i_mode,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_mag,
  output logic                       m_last,
  output logic [WIDTH-1:0]           m_blk_peak,
  output logic [$clog2(WIDTH)-1:0]   m_blk_shift
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(BLOCK_LEN);

  // Leading-zero count; the highest set bit wins, an all-zero word gives WIDTH-1.
  function automatic logic [SHW-1:0] lzc(input logic [WIDTH-1:0] v);
    int n;
    n = WIDTH - 1;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n = WIDTH - 1 - i;
    end
    return SHW'(n);
  endfunction

  logic en;
  logic accept;
  logic v1_reg, v2_reg, v3_reg;

  assign en      = !v3_reg || m_ready;
  assign s_ready = en;
  assign accept  = s_valid && en;

  // ---------------- input counter and block mode ----------------
  logic [CW-1:0] in_cnt_reg;
  logic [1:0]    mode_q_reg;
  logic          cnt_first, cnt_last;
  logic [1:0]    mode_in;

  assign cnt_first = (in_cnt_reg == '0);
  assign cnt_last  = (in_cnt_reg == CW'(BLOCK_LEN - 1));
  assign mode_in   = cnt_first ? i_mode : mode_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_reg <= '0;
      mode_q_reg <= '0;
    end else if (accept) begin
      in_cnt_reg <= cnt_last ? '0 : in_cnt_reg + CW'(1);
      if (cnt_first) mode_q_reg <= i_mode;
    end
  end

  // ---------------- S1: absolute value ----------------
  logic [WIDTH-1:0] raw      [2];
  logic [WIDTH-1:0] abs_next [2];
  logic [WIDTH-1:0] abs_reg  [2];
  logic             last1_reg;
  logic [1:0]       mode1_reg;

  assign raw[0] = s_I;
  assign raw[1] = s_Q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_abs
      if (IS_SIGNED) begin : g_signed
        // Most negative input negates to itself, which reads as 2^(WIDTH-1) unsigned.
        assign abs_next[gi] = raw[gi][WIDTH-1] ? -raw[gi] : raw[gi];
      end else begin : g_unsigned
        assign abs_next[gi] = raw[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg     <= 1'b0;
      last1_reg  <= 1'b0;
      mode1_reg  <= '0;
      abs_reg[0] <= '0;
      abs_reg[1] <= '0;
    end else if (en) begin
      v1_reg <= accept;
      if (accept) begin
        last1_reg  <= cnt_last;
        mode1_reg  <= mode_in;
        abs_reg[0] <= abs_next[0];
        abs_reg[1] <= abs_next[1];
      end
    end
  end

  // ---------------- S2: max/min sort (tie -> max is |Q|) ----------------
  logic [WIDTH-1:0] max2_reg, min2_reg;
  logic             last2_reg;
  logic [1:0]       mode2_reg;
  logic             i_gt;

  assign i_gt = abs_reg[0] > abs_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg    <= 1'b0;
      last2_reg <= 1'b0;
      mode2_reg <= '0;
      max2_reg  <= '0;
      min2_reg  <= '0;
    end else if (en) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        last2_reg <= last1_reg;
        mode2_reg <= mode1_reg;
        max2_reg  <= i_gt ? abs_reg[0] : abs_reg[1];
        min2_reg  <= i_gt ? abs_reg[1] : abs_reg[0];
      end
    end
  end

  // ---------------- S3: estimate, saturate, peak/exponent ----------------
  logic [WIDTH:0]   mx, mn, est, alt;
  logic [WIDTH-1:0] mag_next, peak_next;
  logic [WIDTH-1:0] mag_reg, peak_reg;
  logic [SHW-1:0]   shift_reg;
  logic             last3_reg;
  logic             first_reg;

  always_comb begin
    mx  = {1'b0, max2_reg};
    mn  = {1'b0, min2_reg};
    alt = mx - (mx >> 3) + (mn >> 1);
    est = '0;
    case (mode2_reg)
      2'd0:    est = mx + (mn >> 1);
      2'd1:    est = mx + (mn >> 2);
      2'd2:    est = mx + (mn >> 2) + (mn >> 3);
      default: est = (alt > mx) ? alt : mx;
    endcase
    mag_next = est[WIDTH] ? '1 : est[WIDTH-1:0];
    // A block's first sample restarts the peak, so adjacent blocks never mix.
    peak_next = (first_reg || mag_next > peak_reg) ? mag_next : peak_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_reg    <= 1'b0;
      last3_reg <= 1'b0;
      mag_reg   <= '0;
      peak_reg  <= '0;
      shift_reg <= '0;
      first_reg <= 1'b1;
    end else if (en) begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        last3_reg <= last2_reg;
        mag_reg   <= mag_next;
        peak_reg  <= peak_next;
        shift_reg <= lzc(peak_next);
        first_reg <= last2_reg;
      end
    end
  end

  assign m_valid     = v3_reg;
  assign m_mag       = mag_reg;
  assign m_last      = last3_reg;
  assign m_blk_peak  = peak_reg;
  assign m_blk_shift = shift_reg;

endmodule

// File: tb/tb_complex_magnitude_bfp.sv
// Directed bench: a 16-bit signed instance (BLOCK_LEN=4) and an 8-bit unsigned
// instance, checked with immediate assertions against hand-computed values.
module tb_complex_magnitude_bfp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit signed instance
  logic        rst_n, s_valid, s_ready, m_valid, m_ready, m_last;
  logic [15:0] s_I, s_Q, m_mag, m_blk_peak;
  logic [1:0]  i_mode;
  logic [3:0]  m_blk_shift;

  // 8-bit unsigned instance
  logic       b_valid, b_s_ready, b_m_valid, b_m_ready, b_last;
  logic [7:0] b_i, b_q, b_mag, b_peak;
  logic [1:0] b_mode;
  logic [2:0] b_shift;

  complex_magnitude_bfp #(.WIDTH(16), .IS_SIGNED(1'b1), .BLOCK_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_I(s_I), .s_Q(s_Q), .i_mode(i_mode), .m_valid(m_valid), .m_ready(m_ready),
    .m_mag(m_mag), .m_last(m_last), .m_blk_peak(m_blk_peak), .m_blk_shift(m_blk_shift)
  );

  complex_magnitude_bfp #(.WIDTH(8), .IS_SIGNED(1'b0), .BLOCK_LEN(4)) dut_u8 (
    .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_ready(b_s_ready),
    .s_I(b_i), .s_Q(b_q), .i_mode(b_mode), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_mag(b_mag), .m_last(b_last), .m_blk_peak(b_peak), .m_blk_shift(b_shift)
  );

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int mag;
    bit last;
    int peak;
    int shift;
  } exp_t;
  exp_t exp_q[$];

  bit mon_en   = 1'b1;
  bit rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int i, input int q, input int md, input bit ex,
                      input int emag, input bit elast, input int epeak, input int eshift);
    int n;
    exp_t e;
    if (ex) begin
      e.mag = emag; e.last = elast; e.peak = epeak; e.shift = eshift;
      exp_q.push_back(e);
    end
    s_valid = 1'b1;
    s_I     = 16'(i);
    s_Q     = 16'(q);
    i_mode  = 2'(md);
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_I = '0; s_Q = '0; i_mode = '0; m_ready = 1'b1;
    b_valid = 1'b0; b_i = '0; b_q = '0; b_mode = '0; b_m_ready = 1'b1;

    fork
      begin : monitor
        exp_t e;
        bit held_v;
        logic [15:0] h_mag, h_peak;
        logic [3:0]  h_shift;
        logic        h_last;
        held_v = 1'b0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            held_v = 1'b0;
          end else begin
            if (held_v) begin
              chk("stall_valid", 32'(m_valid), 32'd1);
              chk("stall_mag", 32'(m_mag), 32'(h_mag));
              chk("stall_last", 32'(m_last), 32'(h_last));
              chk("stall_peak", 32'(m_blk_peak), 32'(h_peak));
              chk("stall_shift", 32'(m_blk_shift), 32'(h_shift));
            end
            if (mon_en && m_valid && m_ready) begin
              if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $error("FAIL spurious_beat: observed mag %0d expected no beat", m_mag);
              end else begin
                e = exp_q.pop_front();
                chk("mag", 32'(m_mag), 32'(e.mag));
                chk("last", 32'(m_last), 32'(e.last));
                chk("peak", 32'(m_blk_peak), 32'(e.peak));
                chk("shift", 32'(m_blk_shift), 32'(e.shift));
              end
            end
            held_v  = m_valid && !m_ready;
            h_mag   = m_mag;
            h_last  = m_last;
            h_peak  = m_blk_peak;
            h_shift = m_blk_shift;
          end
        end
      end
      begin : ready_drv
        forever begin
          @(posedge clk);
          #1;
          m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_mag", 32'(m_mag), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_peak", 32'(m_blk_peak), 32'd0);
    chk("rst_shift", 32'(m_blk_shift), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency on the very first sample: valid appears on the third edge
    push(3000, -4000, 0, 1, 5500, 0, 5500, 3);
    chk("lat_edge1", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge3", 32'(m_valid), 32'd1);
    chk("lat_mag", 32'(m_mag), 32'd5500);

    // Block 1 (mode 0, later mode requests ignored)
    push(-32768, 0, 0, 1, 32768, 0, 32768, 0);
    push(16000, 16000, 1, 1, 24000, 0, 32768, 0);
    push(100, 0, 3, 1, 100, 1, 32768, 0);
    // Block 2 (mode 1, mid-block toggles ignored)
    push(16000, 16000, 1, 1, 20000, 0, 20000, 1);
    push(16000, 16000, 0, 1, 20000, 0, 20000, 1);
    push(16000, 16000, 2, 1, 20000, 0, 20000, 1);
    push(16000, 16000, 3, 1, 20000, 1, 20000, 1);
    // Block 3 (mode 2)
    push(16000, 16000, 2, 1, 22000, 0, 22000, 1);
    push(16000, 16000, 0, 1, 22000, 0, 22000, 1);
    push(16000, 16000, 0, 1, 22000, 0, 22000, 1);
    push(16000, 16000, 0, 1, 22000, 1, 22000, 1);
    // Block 4 (mode 3, both branches of the max)
    push(16000, 16000, 3, 1, 22000, 0, 22000, 1);
    push(1000, 0, 0, 1, 1000, 0, 22000, 1);
    push(0, 8, 0, 1, 8, 0, 22000, 1);
    push(-5, -5, 0, 1, 7, 1, 22000, 1);
    // Block 5: peak 900, shift 6
    push(100, 0, 0, 1, 100, 0, 100, 9);
    push(900, 0, 0, 1, 900, 0, 900, 6);
    push(50, 0, 0, 1, 50, 0, 900, 6);
    push(20, 0, 0, 1, 20, 1, 900, 6);
    // Block 6: all zero -> shift 15
    for (int k = 0; k < 4; k++) push(0, 0, 0, 1, 0, k == 3, 0, 15);
    drain("drain_directed");

    // Backpressure with a continuous input stream
    rand_rdy = 1'b1;
    push(300, 0, 0, 1, 300, 0, 300, 7);
    push(100, 0, 0, 1, 100, 0, 300, 7);
    push(200, 0, 0, 1, 200, 0, 300, 7);
    push(50, 0, 0, 1, 50, 1, 300, 7);
    push(-1, 0, 0, 1, 1, 0, 1, 15);
    push(-2, 0, 0, 1, 2, 0, 2, 14);
    push(4000, 0, 0, 1, 4000, 0, 4000, 4);
    push(-7, 0, 0, 1, 7, 1, 4000, 4);
    for (int k = 0; k < 4; k++) push(0, 0, 0, 1, 0, k == 3, 0, 15);
    drain("drain_backpressure");
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-block with samples in flight
    mon_en = 1'b0;
    push(500, 0, 0, 0, 0, 0, 0, 0);
    push(600, 0, 0, 0, 0, 0, 0, 0);
    push(700, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    chk("pre_rst_mag", 32'(m_mag), 32'd500);
    chk("pre_rst_peak", 32'(m_blk_peak), 32'd500);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_mag", 32'(m_mag), 32'd0);
    chk("mid_rst_last", 32'(m_last), 32'd0);
    chk("mid_rst_peak", 32'(m_blk_peak), 32'd0);
    chk("mid_rst_shift", 32'(m_blk_shift), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    push(1, 0, 0, 1, 1, 0, 1, 15);
    push(2, 0, 0, 1, 2, 0, 2, 14);
    push(3, 0, 0, 1, 3, 0, 3, 14);
    push(4, 0, 0, 1, 4, 1, 4, 13);
    drain("drain_post_reset");
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(m_valid), 32'd0);

    // 8-bit unsigned: saturation in every mode, then zeros
    for (int md = 0; md < 5; md++) begin
      for (int j = 0; j < 4; j++) begin
        b_valid = 1'b1;
        b_i     = (md < 4) ? 8'd255 : 8'd0;
        b_q     = (md < 4) ? 8'd255 : 8'd0;
        b_mode  = 2'(md);
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("u8_valid", 32'(b_m_valid), 32'd1);
        chk("u8_mag", 32'(b_mag), (md < 4) ? 32'd255 : 32'd0);
        chk("u8_last", 32'(b_last), (j == 3) ? 32'd1 : 32'd0);
        if (j == 3) begin
          chk("u8_peak", 32'(b_peak), (md < 4) ? 32'd255 : 32'd0);
          chk("u8_shift", 32'(b_shift), (md < 4) ? 32'd0 : 32'd7);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/complex_magnitude_bfp.md
# complex_magnitude_bfp

Pipelined, parametrised complex-magnitude estimator with valid/ready streaming and per-block peak and exponent tracking. It computes |I + jQ| with a run-time selectable alpha-max/beta-min estimator. It also reports, on the last sample of every BLOCK_LEN-sample block, the block peak magnitude and the left-shift (leading-zero count) that normalises it. The block sits between the FFT/channeliser output and the block-floating-point normaliser, which consumes the exponent.

## Interface
- WIDTH, 16, bit width of I, Q and magnitude (>= 4)
- IS_SIGNED, 1, 1 = I/Q are two's complement, 0 = unsigned
- BLOCK_LEN, 64, samples per block (>= 2)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset; one clock domain
- s_valid  in  1  input sample valid
- s_ready  out  1  input may be accepted
- s_I  in  WIDTH  in-phase sample
- s_Q  in  WIDTH  quadrature sample
- i_mode  in  2  estimator select, sampled on the first accepted sample of each block
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts
- m_mag  out  WIDTH  magnitude estimate, unsigned, saturated
- m_last  out  1  marks the final sample of a block
- m_blk_peak  out  WIDTH  running block peak including the current beat; meaningful when m_last=1
- m_blk_shift  out  $clog2(WIDTH)  leading zeros of m_blk_peak, capped at WIDTH-1; meaningful when m_last=1

## Operation
- Pipeline has 3 register stages: S1 = absolute value, S2 = max/min sort, S3 = estimate, saturate, peak update.
- Each stage carries valid, last and mode (2 b) alongside its data.
- **Absolute value (IS_SIGNED=1):**
  - abs = (x<0) ? -x : x, held as WIDTH unsigned bits.
  - The most negative input maps to 2^(WIDTH-1).
  - With IS_SIGNED=0 the inputs pass through unchanged.
- **Sort:** max = larger of |I|,|Q|; min = the other. On a tie, max = |Q|.
- **Estimators**, computed in WIDTH+1 bits with truncating shifts:
  - mode 0: max + (min>>1)
  - mode 1: max + (min>>2)
  - mode 2: max + (min>>2) + (min>>3)
  - mode 3: larger of max and (max - (max>>3)) + (min>>1)
- **Saturation:** if the sum exceeds 2^WIDTH-1, m_mag = 2^WIDTH-1.
- **Input counter** in_cnt (0..BLOCK_LEN-1):
  - Increments on each s_valid&&s_ready and wraps to 0 after BLOCK_LEN-1.
  - When in_cnt==0 on acceptance, i_mode is latched into mode_q and used for this sample and the rest of the block.
  - The sample accepted with in_cnt==BLOCK_LEN-1 is tagged last.
- **Peak register:**
  - On each S3 load, peak = (first sample of block) ? mag : max(peak, mag).
  - The first sample of a block is the one following a last, or the first after reset.
  - m_blk_peak = peak register; m_blk_shift = leading-zero count of it.
  - A zero peak gives a shift of WIDTH-1.
- **Mode changes:** changing i_mode mid-block has no effect until the next block's first sample. Samples in flight keep their own tagged mode.

## Timing
- **Stall:** enable en = !m_valid || m_ready. When en=0 all three stages hold.
- **Input ready:** s_ready = en. This is combinational from m_ready; it is the only combinational input-to-output path.
- **Bubbles:** not compressed. An empty stage advances only when en=1.
- **Latency:** 3 cycles from acceptance to m_valid when m_ready=1. Throughput is 1 sample/cycle.
- **Output stability:** while m_valid=1 and m_ready=0, m_mag, m_last, m_blk_peak and m_blk_shift hold stable.
- **Reset:** all valids, in_cnt, mode_q, peak and every output go to 0 (s_ready reads 1).
  - Reset mid-block discards in-flight samples.
  - The next accepted sample starts a new block.
- **Simultaneous events:** when the last sample of one block and the first sample of the next are in adjacent stages, the peak restarts cleanly. No cross-block mixing is allowed.

## Test plan
- **Basic estimate and latency:** WIDTH=16, signed, mode 0, m_ready=1; drive I=3000, Q=-4000 → m_mag=5500, 3 cycles after acceptance. Drive I=-32768, Q=0 → m_mag=32768.
- **Modes on I=Q=16000:**
  - mode 0 → 24000
  - mode 1 → 20000
  - mode 2 → 22000
  - mode 3 → 22000
  - Each result must match the mode tagged at block start.
- **Saturation, unsigned:** WIDTH=8, IS_SIGNED=0, I=Q=255 → m_mag=255 in every mode. I=Q=0 → m_mag=0.
- **Block peak and exponent:** BLOCK_LEN=4; mags 100, 900, 50, 20 (mode 0, Q=0) → m_last on the 4th beat, m_blk_peak=900, m_blk_shift=6. The next block of all zeros → peak 0, shift 15.
- **Backpressure:** random m_ready with a continuous s_valid stream → no sample lost or duplicated. Outputs stay stable while stalled. m_last spacing is exactly BLOCK_LEN transfers.
- **Reset and mode change:**
  - Assert rst_n low mid-block, then release → outputs all 0 during reset. The first post-reset sample starts a new block and m_last comes BLOCK_LEN samples later.
  - Toggle i_mode mid-block → no effect until the next block's first sample.
